q_update_pipe: RTL and testbench
================================

Name: q_update_pipe

Overview:
- Parametrised Q-learning update engine; next generation of the fixed 2-bit-action pipeline.
- Holds an on-chip Q-table of 2^STATE_W x 2^ACT_W signed entries.
- Accepts (state, action, reward, next_state) transactions over a valid/ready handshake and applies Q(s,a) += alpha*(r + gamma*max_a' Q(s',a') - Q(s,a)), using shift-based alpha/gamma.
- Two-stage pipeline with write-to-read forwarding, output backpressure and a verification read port.

Parameters:
STATE_W, 4, state index width; table has 2^STATE_W rows
ACT_W, 2, action index width; N_ACTIONS = 2^ACT_W columns
Q_W, 24, signed Q-value width
R_W, 16, signed reward width (R_W <= Q_W)
ALPHA_SH, 2, alpha = 2^-ALPHA_SH (0 means alpha = 1)
GAMMA_SH, 3, gamma = 1 - 2^-GAMMA_SH (0 means gamma = 0)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  transaction present
in_ready  out  1  transaction accepted when in_valid && in_ready
state  in  STATE_W  current state s
action  in  ACT_W  action a
reward  in  R_W  signed reward r
next_state  in  STATE_W  next state s'
out_valid  out  1  result present
out_ready  in  1  downstream accepts result
out_state  out  STATE_W  s of the completed update
out_action  out  ACT_W  a of the completed update
q_out  out  Q_W  new Q(s,a) as written to the table
sat  out  1  q_out was clamped
upd_cnt  out  32  number of completed table writes; wraps at 2^32
rd_state  in  STATE_W  debug read row
rd_action  in  ACT_W  debug read column
rd_q  out  Q_W  registered table[rd_state][rd_action]

Behaviour:
- Reset (rst high at an edge):
  - All table entries become 0.
  - out_valid, sat, upd_cnt, rd_q, q_out, out_state, out_action become 0.
  - The stage-1 valid flag clears; in-flight transactions are discarded and never written.
  - rst has priority over every other event.
- stall = out_valid && !out_ready; in_ready = !stall (combinational, also high during reset cycles).
- Stage 1 (accept edge k):
  - Registers s, a, r, s', qsa = table[s][a] and row[j] = table[s'][j] for all j.
  - Forwarding: if the stage-2 write happens at the same edge k to entry (x,y), any captured operand addressing (x,y) takes the newly written value, not the old table value.
- Stage 2 (edge k+1, when not stalled):
  - Computes combinationally from stage-1 registers.
  - Writes the table, loads the output registers and sets out_valid.
  - Increments upd_cnt.
  - Result latency is 2 edges; out_valid is visible after edge k+1.
- Throughput: one transaction per cycle while out_ready is high.
  - Back-to-back updates to the same or dependent entries must see each other's results through forwarding.
- Stall:
  - Stage-1 and output registers hold; no table write; upd_cnt holds.
  - If in_valid arrives while stalled, it is not accepted.
- out_valid drops after an edge with out_ready high and no new stage-1 transaction.
- Arithmetic (signed two's complement, internal width Q_W+3, arithmetic right shifts rounding toward minus infinity):
  - maxq = max over j of row[j]
  - disc = maxq - (maxq >>> GAMMA_SH), or 0 if GAMMA_SH = 0
  - target = sext(r) + disc
  - delta = target - qsa
  - qn = qsa + (delta >>> ALPHA_SH)
  - q_out = qn clamped to [-2^(Q_W-1), 2^(Q_W-1)-1]; sat = 1 iff clamped.
- Clamped value is the value written to the table.
- s == s' is legal; row values are forwarded like qsa.
- rd_q: each edge loads table[rd_state][rd_action] as it was before that edge's write (no forwarding). Updated on stall cycles too.

Test Plan:
- Default params, after reset read all 64 entries -> rd_q = 0; then accept s=1,a=2,r=100,s'=3 -> out_valid 2 edges later, q_out=25, sat=0, upd_cnt=1, rd_q(1,2)=25 next read.
- Back-to-back forwarding: s=1,a=2,r=100,s'=1 in two consecutive cycles from zero table -> q_out 25 then 49 (second sees qsa=25, maxq=25, disc=22, target=122, delta=97).
- Negative reward: s=0,a=0,r=-7,s'=4 from zero -> q_out = -2 (floor of -7/4), rd_q(0,0) = -2.
- Saturation (Q_W=16, R_W=16, ALPHA_SH=0):
  - s=0,a=0,r=32767,s'=5 -> q_out 32767, sat=0.
  - Then s=0,a=0,r=32767,s'=0 -> target 61439 -> q_out 32767, sat=1.
- Backpressure:
  - Hold out_ready=0 with out_valid=1 and a stage-1 transaction pending -> in_ready=0, q_out/out_state/upd_cnt stable for 5 cycles, table unchanged.
  - Raise out_ready -> pending result emerges next edge.
- Reset mid-stream: assert rst with stage 1 and output both valid -> next edge out_valid=0, upd_cnt=0, all rd_q reads 0, the discarded transaction is never written.

Source files
------------

// File: rtl/q_update_pipe.sv
// Two-stage Q-learning update engine with an on-chip Q-table, write-to-read
// forwarding into stage 1, output backpressure and a registered debug read port.
`timescale 1ns/1ps
module q_update_pipe #(
    parameter int STATE_W  = 4,
    parameter int ACT_W    = 2,
    parameter int Q_W      = 24,
    parameter int R_W      = 16,
    parameter int ALPHA_SH = 2,
    parameter int GAMMA_SH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] state,
    input  logic [ACT_W-1:0]   action,
    input  logic [R_W-1:0]     reward,
    input  logic [STATE_W-1:0] next_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic [ACT_W-1:0]   out_action,
    output logic [Q_W-1:0]     q_out,
    output logic               sat,
    output logic [31:0]        upd_cnt,
    input  logic [STATE_W-1:0] rd_state,
    input  logic [ACT_W-1:0]   rd_action,
    output logic [Q_W-1:0]     rd_q
);

    localparam int N_ACT = 1 << ACT_W;
    localparam int IDX_W = STATE_W + ACT_W;
    localparam int N_ENT = 1 << IDX_W;
    localparam int IW    = Q_W + 3;
    localparam logic signed [IW-1:0] QMAX = {4'b0000, {(Q_W-1){1'b1}}};
    localparam logic signed [IW-1:0] QMIN = {4'b1111, {(Q_W-1){1'b0}}};

    function automatic logic signed [IW-1:0] sx_q(input logic [Q_W-1:0] v);
        return {{3{v[Q_W-1]}}, v};
    endfunction

    logic [Q_W-1:0]     tbl_q [N_ENT];

    logic               s1_valid_q;
    logic [STATE_W-1:0] s1_state_q;
    logic [ACT_W-1:0]   s1_action_q;
    logic [R_W-1:0]     s1_reward_q;
    logic [Q_W-1:0]     s1_qsa_q;
    logic [Q_W-1:0]     s1_row_q [N_ACT];

    logic               out_valid_q;
    logic [STATE_W-1:0] out_state_q;
    logic [ACT_W-1:0]   out_action_q;
    logic [Q_W-1:0]     q_out_q;
    logic               sat_q;
    logic [31:0]        upd_cnt_q;
    logic [31:0]        upd_cnt_d;
    logic [Q_W-1:0]     rd_q_q;

    logic               stall;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic signed [IW-1:0] maxq, disc, target, delta, qn;
    logic [Q_W-1:0]     q_new;
    logic               sat_new;
    logic [Q_W-1:0]     qsa_d;
    logic [Q_W-1:0]     row_d [N_ACT];

    assign stall     = out_valid_q && !out_ready;
    assign in_ready  = !stall;
    assign wr_en     = s1_valid_q && !stall;
    assign wr_idx    = {s1_state_q, s1_action_q};
    assign upd_cnt_d = upd_cnt_q + 32'd1;

    // Stage 2 datapath: all arithmetic in Q_W+3 bits so no intermediate overflows.
    always_comb begin
        maxq = sx_q(s1_row_q[0]);
        for (int j = 1; j < N_ACT; j++) begin
            if (sx_q(s1_row_q[j]) > maxq) maxq = sx_q(s1_row_q[j]);
        end
        if (GAMMA_SH == 0) disc = '0;
        else               disc = maxq - (maxq >>> GAMMA_SH);
        target  = $signed({{(IW-R_W){s1_reward_q[R_W-1]}}, s1_reward_q}) + disc;
        delta   = target - sx_q(s1_qsa_q);
        qn      = sx_q(s1_qsa_q) + (delta >>> ALPHA_SH);
        q_new   = qn[Q_W-1:0];
        sat_new = 1'b0;
        if (qn > QMAX) begin
            q_new   = QMAX[Q_W-1:0];
            sat_new = 1'b1;
        end else if (qn < QMIN) begin
            q_new   = QMIN[Q_W-1:0];
            sat_new = 1'b1;
        end
    end

    // Operands captured at the same edge as a stage-2 write see the new value.
    always_comb begin
        qsa_d = (wr_en && wr_idx == {state, action}) ? q_new : tbl_q[{state, action}];
        for (int j = 0; j < N_ACT; j++) begin
            row_d[j] = (wr_en && wr_idx == {next_state, ACT_W'(j)}) ? q_new
                                                                    : tbl_q[{next_state, ACT_W'(j)}];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ENT; i++) tbl_q[i] <= '0;
            for (int j = 0; j < N_ACT; j++) s1_row_q[j] <= '0;
            s1_valid_q   <= 1'b0;
            s1_state_q   <= '0;
            s1_action_q  <= '0;
            s1_reward_q  <= '0;
            s1_qsa_q     <= '0;
            out_valid_q  <= 1'b0;
            out_state_q  <= '0;
            out_action_q <= '0;
            q_out_q      <= '0;
            sat_q        <= 1'b0;
            upd_cnt_q    <= '0;
            rd_q_q       <= '0;
        end else begin
            rd_q_q <= tbl_q[{rd_state, rd_action}];
            if (wr_en) begin
                tbl_q[wr_idx] <= q_new;
                out_state_q   <= s1_state_q;
                out_action_q  <= s1_action_q;
                q_out_q       <= q_new;
                sat_q         <= sat_new;
                upd_cnt_q     <= upd_cnt_d;
            end
            if (!stall) begin
                out_valid_q <= s1_valid_q;
                s1_valid_q  <= in_valid;
                if (in_valid) begin
                    s1_state_q  <= state;
                    s1_action_q <= action;
                    s1_reward_q <= reward;
                    s1_qsa_q    <= qsa_d;
                    for (int j = 0; j < N_ACT; j++) s1_row_q[j] <= row_d[j];
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_state  = out_state_q;
    assign out_action = out_action_q;
    assign q_out      = q_out_q;
    assign sat        = sat_q;
    assign upd_cnt    = upd_cnt_q;
    assign rd_q       = rd_q_q;

endmodule

// File: tb/tb_q_update_pipe.sv
// Bench for q_update_pipe: sequential Q-update reference model feeding a
// scoreboard queue, plus a saturating-configuration instance.
`timescale 1ns/1ps
module tb_q_update_pipe;

    localparam int STATE_W = 4;
    localparam int ACT_W   = 2;
    localparam int Q_W     = 24;
    localparam int R_W     = 16;
    localparam int ASH     = 2;
    localparam int GSH     = 3;
    localparam int EXP_W   = STATE_W + ACT_W + Q_W + 1;
    localparam int SQ_W    = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, in_valid, in_ready, out_valid, out_ready, sat;
    logic [STATE_W-1:0] state, next_state, out_state, rd_state;
    logic [ACT_W-1:0]   action, out_action, rd_action;
    logic [R_W-1:0]     reward;
    logic [Q_W-1:0]     q_out, rd_q;
    logic [31:0]        upd_cnt;

    logic               s_rst, s_in_valid, s_in_ready, s_out_valid, s_sat;
    logic [STATE_W-1:0] s_state, s_next_state, s_out_state;
    logic [ACT_W-1:0]   s_action, s_out_action;
    logic [15:0]        s_reward;
    logic [SQ_W-1:0]    s_q_out, s_rd_q;
    logic [31:0]        s_upd_cnt;

    q_update_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .state(state), .action(action), .reward(reward), .next_state(next_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .out_action(out_action), .q_out(q_out), .sat(sat), .upd_cnt(upd_cnt),
        .rd_state(rd_state), .rd_action(rd_action), .rd_q(rd_q)
    );

    q_update_pipe #(.Q_W(SQ_W), .R_W(16), .ALPHA_SH(0), .GAMMA_SH(3)) dut_sat (
        .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .state(s_state), .action(s_action), .reward(s_reward), .next_state(s_next_state),
        .out_valid(s_out_valid), .out_ready(1'b1), .out_state(s_out_state),
        .out_action(s_out_action), .q_out(s_q_out), .sat(s_sat), .upd_cnt(s_upd_cnt),
        .rd_state(4'd0), .rd_action(2'd0), .rd_q(s_rd_q)
    );

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    logic [EXP_W-1:0] exp_q[$];
    longint mt [16][4];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic longint fdiv(input longint x, input longint d);
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    // Q(s,a) <- Q + alpha*(r + gamma*maxQ' - Q), clamped to the Q_W signed range.
    function automatic void model(input longint qsa, input longint maxq, input longint r,
                                  input int qw, input int ash, input int gsh,
                                  output longint qo, output bit so);
        longint disc, qn, hi, lo;
        disc = (gsh == 0) ? 0 : maxq - fdiv(maxq, longint'(1) << gsh);
        qn   = qsa + fdiv(r + disc - qsa, longint'(1) << ash);
        hi   = (longint'(1) << (qw - 1)) - 1;
        lo   = -(longint'(1) << (qw - 1));
        so   = 1'b0;
        qo   = qn;
        if (qn > hi) begin qo = hi; so = 1'b1; end
        else if (qn < lo) begin qo = lo; so = 1'b1; end
    endfunction

    function automatic void model_accept(input int s, input int a, input int r, input int ns);
        longint mx, q;
        bit so;
        mx = mt[ns][0];
        for (int j = 1; j < 4; j++) if (mt[ns][j] > mx) mx = mt[ns][j];
        model(mt[s][a], mx, r, Q_W, ASH, GSH, q, so);
        mt[s][a] = q;
        exp_q.push_back({STATE_W'(s), ACT_W'(a), Q_W'(q), so});
    endfunction

    // Monitor: every handshaked result is compared against the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                logic [EXP_W-1:0] e;
                logic signed [Q_W-1:0] eq;
                e  = exp_q.pop_front();
                eq = e[Q_W:1];
                n_done++;
                check("out_state", longint'(out_state), longint'(e[EXP_W-1 -: STATE_W]));
                check("out_action", longint'(out_action), longint'(e[Q_W+ACT_W:Q_W+1]));
                check("q_out", longint'($signed(q_out)), longint'(eq));
                check("sat", longint'(sat), longint'(e[0]));
                check("upd_cnt", longint'(upd_cnt), longint'(n_done));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input int s, input int a, input int r, input int ns);
        state = STATE_W'(s); action = ACT_W'(a); reward = R_W'(r); next_state = STATE_W'(ns);
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(s, a, r, ns);
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle(1);
        check("drain_left", exp_q.size(), 0);
        idle(2);
    endtask

    task automatic check_rd(input int s, input int a);
        rd_state = STATE_W'(s); rd_action = ACT_W'(a);
        idle(1);
        check("rd_q", longint'($signed(rd_q)), mt[s][a]);
    endtask

    task automatic sweep();
        for (int s = 0; s < 16; s++)
            for (int a = 0; a < 4; a++) check_rd(s, a);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_q.delete();
        n_done = 0;
        for (int s = 0; s < 16; s++) for (int a = 0; a < 4; a++) mt[s][a] = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        longint pre_b, sq, smx;
        bit ssat;
        logic signed [Q_W-1:0] head_q;
        bit pend;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        state = '0; action = '0; reward = '0; next_state = '0;
        rd_state = '0; rd_action = '0;
        s_rst = 1'b1; s_in_valid = 1'b0; s_state = '0; s_action = '0;
        s_reward = '0; s_next_state = '0;
        for (int s = 0; s < 16; s++) for (int a = 0; a < 4; a++) mt[s][a] = 0;
        idle(2);
        rst = 1'b0; s_rst = 1'b0;

        check("rst_out_valid", out_valid, 0);
        check("rst_upd_cnt", upd_cnt, 0);
        check("rst_q_out", q_out, 0);
        check("rst_sat", sat, 0);
        check("rst_in_ready", in_ready, 1);
        sweep();

        // Basic update and 2-edge latency
        send(1, 2, 100, 3);
        check("lat_edge_k", out_valid, 0);
        idle(1);
        check("lat_edge_k1", out_valid, 1);
        drain();
        check_rd(1, 2);

        // Back-to-back dependent updates through forwarding
        do_reset();
        send(1, 2, 100, 1);
        send(1, 2, 100, 1);
        drain();
        check_rd(1, 2);

        // Negative reward rounds toward minus infinity
        do_reset();
        send(0, 0, -7, 4);
        drain();
        check_rd(0, 0);

        // Backpressure: output full, stage 1 pending, new input refused
        do_reset();
        out_ready = 1'b0;
        send(2, 1, 500, 3);
        pre_b = mt[3][0];
        send(3, 0, -300, 2);
        rd_state = 4'd3; rd_action = 2'd0;
        state = 4'd2; action = 2'd1; reward = 16'd77; next_state = 4'd0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            head_q = exp_q[0][Q_W:1];
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_q_out", longint'($signed(q_out)), longint'(head_q));
            check("stall_out_state", out_state, exp_q[0][EXP_W-1 -: STATE_W]);
            check("stall_upd_cnt", upd_cnt, n_done + 1);
            if (i > 0) check("stall_tbl", longint'($signed(rd_q)), pre_b);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(2, 1, 77, 0);
        drain();
        check_rd(2, 1);
        check_rd(3, 0);

        // Reset with both stages occupied discards the pending transaction
        do_reset();
        out_ready = 1'b0;
        send(5, 3, 1000, 6);
        send(6, 2, 2000, 5);
        check("pre_rst_valid", out_valid, 1);
        do_reset();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_upd_cnt", upd_cnt, 0);
        check("mid_rst_q_out", q_out, 0);
        out_ready = 1'b1;
        idle(3);
        check("mid_rst_no_write", upd_cnt, 0);
        sweep();

        // Randomized traffic with random backpressure
        do_reset();
        pend = 1'b0;
        repeat (400) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                state      = STATE_W'($urandom_range(0, 1) != 0 ? $urandom_range(0, 1) : $urandom_range(0, 15));
                action     = ACT_W'($urandom_range(0, 3));
                next_state = STATE_W'($urandom_range(0, 1) != 0 ? $urandom_range(0, 1) : $urandom_range(0, 15));
                reward     = R_W'($urandom_range(0, 65535));
                in_valid   = 1'b1;
                pend       = 1'b1;
            end else if (!pend) begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (pend && in_ready) begin
                model_accept(int'(state), int'(action), int'($signed(reward)), int'(next_state));
                pend = 1'b0;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();
        sweep();

        // Saturating configuration: Q_W=16, alpha=1
        model(0, 0, 32767, SQ_W, 0, 3, sq, ssat);
        for (int t = 0; t < 2; t++) begin
            s_state = 4'd0; s_action = 2'd0; s_reward = 16'd32767;
            s_next_state = (t == 0) ? 4'd5 : 4'd0;
            s_in_valid = 1'b1;
            @(negedge clk);
            check("sat_in_ready", s_in_ready, 1);
            @(posedge clk); #1;
            s_in_valid = 1'b0;
            for (int i = 0; i < 10 && !s_out_valid; i++) idle(1);
            check("sat_out_valid", s_out_valid, 1);
            check("sat_q_out", longint'($signed(s_q_out)), sq);
            check("sat_flag", s_sat, ssat);
            check("sat_upd_cnt", s_upd_cnt, t + 1);
            smx = sq;
            model(sq, smx, 32767, SQ_W, 0, 3, sq, ssat);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
